f3m_addsub_ctrl: RTL and testbench

- Sequenced GF(3^m) add/subtract/negate unit for the pairing datapath.
- Accepts two packed GF(3^m) operands on a start/done handshake and processes P digits per cycle using P parallel single-digit GF(3) lanes.
- Returns the packed result after ceil(M/P) cycles.
- Lets the coefficient-wise vector ops share a narrow digit datapath instead of M full-width lanes.

---
 rtl/f3m_addsub_ctrl_pkg.sv | 35 +++
 rtl/f3m_addsub_ctrl_lane.sv | 30 +++
 rtl/f3m_addsub_ctrl.sv | 125 ++++++++++++
 tb/tb_f3m_addsub_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/f3m_addsub_ctrl_pkg.sv
// Shared encodings and GF(3) digit helpers for the sequenced add/sub unit.
package f3m_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_NEG = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  localparam logic [1:0] D0   = 2'b00;
  localparam logic [1:0] D1   = 2'b01;
  localparam logic [1:0] D2   = 2'b10;
  localparam logic [1:0] DILL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Negation of a legal digit is a swap of its two bits (0->0, 1->2, 2->1).
  function automatic logic [1:0] f3_neg(input logic [1:0] d);
    return {d[0], d[1]};
  endfunction

  // Sum of two legal digits mod 3.
  function automatic logic [1:0] f3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = 3'(x) + 3'(y);
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/f3m_addsub_ctrl_lane.sv
// Single-digit GF(3) add/sub/negate lane; illegal digits are treated as 0 and flagged.
module f3_addsub_lane
  import f3m_addsub_ctrl_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] op,
  output logic [1:0] c,
  output logic       ill
);

  logic       b_used;
  logic [1:0] a_v;
  logic [1:0] b_v;

  // Sanitise inputs, then apply the op; reserved op behaves as SUB.
  always_comb begin
    b_used = (op != OP_NEG);
    a_v    = (a == DILL) ? D0 : a;
    b_v    = (b_used && (b != DILL)) ? b : D0;
    ill    = (a == DILL) || (b_used && (b == DILL));
    c      = D0;
    case (op)
      OP_ADD:  c = f3_add(a_v, b_v);
      OP_NEG:  c = f3_neg(a_v);
      default: c = f3_add(a_v, f3_neg(b_v));
    endcase
  end

endmodule

// File: rtl/f3m_addsub_ctrl.sv
// Sequenced GF(3^m) add/sub/negate: P digit lanes walk the operands over ceil(M/P) cycles.
module f3m_addsub_ctrl
  import f3m_addsub_ctrl_pkg::*;
#(
  parameter int unsigned M = 97,
  parameter int unsigned P = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [2*M-1:0] A,
  input  logic [2*M-1:0] B,
  output logic [2*M-1:0] C,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int unsigned N  = (M + P - 1) / P;
  localparam int unsigned W  = 2 * N * P;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     res_q, res_d;
  logic [2*M-1:0]   c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [2*P-1:0]   chunk;
  logic [P-1:0]     ill_v;

  // P parallel digit lanes working on the low chunk of the operand shifters.
  for (genvar i = 0; i < int'(P); i++) begin : g_lane
    f3_addsub_lane u_lane (
      .a   (a_q[2*i +: 2]),
      .b   (b_q[2*i +: 2]),
      .op  (op_q),
      .c   (chunk[2*i +: 2]),
      .ill (ill_v[i])
    );
  end

  // Next-state logic: accept, chunk processing and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = W'(A);
          b_d     = W'(B);
          op_d    = op;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        // Result chunks enter at the top so the first chunk ends at digit 0.
        res_d = (res_q >> (2 * P)) | (W'(chunk) << (W - 2 * P));
        c_d   = res_d[2*M-1:0];
        a_d   = a_q >> (2 * P);
        b_d   = b_q >> (2 * P);
        cnt_d = cnt_q + CW'(1);
        err_d = err_q | (|ill_v) | (op_q == OP_RSV);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      res_q   <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign C    = c_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_f3m_addsub_ctrl.sv
// Directed bench for f3m_addsub_ctrl: small M=5/P=2 instance plus a default-size instance.
module tb_f3m_addsub_ctrl;

  logic clk;
  logic reset;

  // Small instance (M=5, P=2, N=3)
  logic        s_start;
  logic [1:0]  s_op;
  logic [9:0]  s_A, s_B, s_C;
  logic        s_busy, s_done, s_err;

  // Default instance (M=97, P=8, N=13)
  logic          b_start;
  logic [1:0]    b_op;
  logic [193:0]  b_A, b_B, b_C;
  logic          b_busy, b_done, b_err;

  int checks = 0;
  int errors = 0;

  f3m_addsub_ctrl #(.M(5), .P(2)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .op(s_op), .A(s_A), .B(s_B),
    .C(s_C), .busy(s_busy), .done(s_done), .err(s_err)
  );

  f3m_addsub_ctrl u_big (
    .clk(clk), .reset(reset), .start(b_start), .op(b_op), .A(b_A), .B(b_B),
    .C(b_C), .busy(b_busy), .done(b_done), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] c;
    logic       err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  // One small-instance operation; scrambles inputs during RUN to show they are ignored.
  task automatic run_small(input logic [9:0] a, input logic [9:0] b, input logic [1:0] o,
                           input bit hold, input logic [9:0] exp_c, input logic exp_err,
                           input string tag);
    int lat;
    @(negedge clk);
    s_A = a; s_B = b; s_op = o; s_start = 1'b1;
    @(negedge clk);
    chk($sformatf("%s_acc_busy", tag), s_busy, 1);
    chk($sformatf("%s_acc_done", tag), s_done, 0);
    chk($sformatf("%s_acc_err", tag), s_err, 0);
    if (!hold) s_start = 1'b0;
    s_A = ~a; s_B = ~b; s_op = ~o;
    lat = 0;
    while (s_done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("%s_latency", tag), lat, 3);
    chk($sformatf("%s_C", tag), s_C, exp_c);
    chk($sformatf("%s_err", tag), s_err, exp_err);
    chk($sformatf("%s_busy_end", tag), s_busy, 0);
  endtask

  initial begin
    logic [193:0] exp_big;
    int lat;
    int da, db, dc;
    bit bad;

    vecs[0] = '{op: 2'b01, a: 10'h249, b: 10'h11A, c: 10'h162, err: 1'b0};
    vecs[1] = '{op: 2'b00, a: 10'h249, b: 10'h11A, c: 10'h054, err: 1'b0};
    vecs[2] = '{op: 2'b10, a: 10'h249, b: 10'h3FF, c: 10'h186, err: 1'b0};
    vecs[3] = '{op: 2'b01, a: 10'h24B, b: 10'h000, c: 10'h248, err: 1'b1};
    vecs[4] = '{op: 2'b11, a: 10'h249, b: 10'h11A, c: 10'h162, err: 1'b1};
    vecs[5] = '{op: 2'b00, a: 10'h249, b: 10'h003, c: 10'h249, err: 1'b1};

    reset = 1'b1;
    s_start = 1'b0; s_op = 2'b00; s_A = '0; s_B = '0;
    b_start = 1'b0; b_op = 2'b00; b_A = '0; b_B = '0;
    repeat (2) @(negedge clk);
    chk("rst_C", s_C, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_err", s_err, 0);
    reset = 1'b0;

    // Table-driven operations, each followed by a held-done window.
    for (int i = 0; i < 6; i++) begin
      run_small(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, vecs[i].c, vecs[i].err,
                $sformatf("vec%0d", i));
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_done_held", i), s_done, 1);
      chk($sformatf("vec%0d_C_held", i), s_C, vecs[i].c);
    end

    // start held high through RUN: no restart until DONE, then immediate re-accept.
    run_small(10'h249, 10'h11A, 2'b01, 1'b1, 10'h162, 1'b0, "hold");
    @(negedge clk);
    chk("hold_reaccept_done", s_done, 0);
    chk("hold_reaccept_busy", s_busy, 1);
    s_start = 1'b0;
    lat = 0;
    while (s_done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_second_latency", lat, 3);

    // Reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    s_A = 10'h249; s_B = 10'h11A; s_op = 2'b00; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", s_busy, 0);
    chk("abort_done", s_done, 0);
    chk("abort_C", s_C, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_idle_done", s_done, 0);
    chk("abort_idle_busy", s_busy, 0);
    run_small(10'h249, 10'h11A, 2'b00, 1'b0, 10'h054, 1'b0, "post_abort");

    // Default-size instance against a digit-wise reference model.
    for (int it = 0; it < 6; it++) begin
      b_op = 2'(it % 3);
      for (int i = 0; i < 97; i++) begin
        da = $urandom_range(0, 2);
        db = $urandom_range(0, 2);
        case (it % 3)
          0: dc = (da + db) % 3;
          1: dc = (da + 3 - db) % 3;
          default: dc = (3 - da) % 3;
        endcase
        b_A[2*i +: 2] = 2'(da);
        b_B[2*i +: 2] = 2'(db);
        exp_big[2*i +: 2] = 2'(dc);
      end
      @(negedge clk);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      lat = 0;
      while (b_done !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("big%0d_latency", it), lat, 13);
      chk($sformatf("big%0d_C", it), b_C, exp_big);
      chk($sformatf("big%0d_err", it), b_err, 0);
      bad = 1'b0;
      for (int i = 0; i < 97; i++) if (b_C[2*i +: 2] == 2'b11) bad = 1'b1;
      chk($sformatf("big%0d_legal", it), bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
